transfer_datapath: RTL and testbench
====================================

# transfer_datapath

Register-transfer datapath on the receiving end of the `control_unit` command bus. Each clock it executes the transfer named on `i_transfer_cmd`, along with any PC/SP increment or decrement. It holds PC, SP, MA, MD, IR, A and AP, and drives the memory and I/O ports. It returns the current opcode to the control unit and feeds operands to the external ALU.

## Interface
- `AW`, default 8: address width for PC, SP, MA and AP.
- `DW`, default 8: data width for MD, IR, A and memory data; `DW` = `AW` is required.
- `RESET_PC`, default 'h00: PC value after reset.
- `RESET_SP`, default 'hFF: SP value after reset (full-descending stack).
- `i_clk` in 1: clock.
- `i_rstn` in 1: reset, asynchronous, active-low.
- `i_transfer_cmd` in 4: transfer code 0x0–0xF, one per cycle.
- `i_inc_pc` in 1: PC ← PC+1 this cycle.
- `i_inc_dec_sp` in 2: 01 = SP+1, 10 = SP−1, 00 and 11 = hold.
- `i_alu_res_to_ap` in 1: selects AP as the cmd 0xA destination; 0 selects A.
- `i_reset_ir` in 1: clear IR to 0x00.
- `i_alu_result` in DW: ALU result R.
- `o_opcode` out DW: opcode presented to the control unit.
- `o_alu_op_a` out DW: A.
- `o_alu_op_b` out DW: MD.
- `o_mem_addr` out AW: MA.
- `o_mem_we` out 1: write strobe.
- `o_mem_wdata` out DW: MD.
- `i_mem_rdata` in DW: memory read data; combinational (asynchronous-read) memory.
- `i_in_data` in DW: input port.
- `o_out_data` out DW: output port register.
- `o_out_valid` out 1: one-cycle pulse when `o_out_data` updates.
- `o_pc` out AW: PC, for debug.
- `o_sp` out AW: SP, for debug.

## Operation
- All register updates occur at the rising edge that ends the cycle in which the command is present.
- Transfer commands:
  - 0x0: no transfer.
  - 0x1: MA←PC.
  - 0x2: MD←`i_mem_rdata`.
  - 0x3: IR←MD.
  - 0x4: MA←MD.
  - 0x5: X←MD.
  - 0x6: MA←AP.
  - 0x7: MA←SP.
  - 0x8: MD←X.
  - 0x9: memory write at MA with MD.
  - 0xA: A or AP ←`i_alu_result`, selected by `i_alu_res_to_ap`.
  - 0xB: PC←MD.
  - 0xC: A←`i_in_data`.
  - 0xD: `o_out_data`←A and `o_out_valid` pulses.
  - 0xE: PC←AP.
  - 0xF: MD←PC.
- Destination X (cmd 0x5 and 0x8):
  - X = AP if IR==0xC1 or IR[1]==1.
  - Otherwise X = A.
- Opcode bypass: `o_opcode` = MD while cmd==0x3, else IR. This lets the control unit decode during IR_MD.
- PC:
  - A load (0xB or 0xE) takes priority over `i_inc_pc` in the same cycle.
  - Otherwise PC increments; cmd 0x1 with `i_inc_pc` loads MA with the pre-increment PC.
  - PC wraps at 2^AW−1 → 0.
- SP:
  - Increments and decrements wrap modulo 2^AW.
  - cmd 0x7 with a simultaneous SP change loads MA with the pre-change SP.
  - Pop (0x7 then 0x2 with SP+1) reads at old SP.
  - Push (SP−1, then 0x7, then 0x9) writes at the new SP.
- IR:
  - `i_reset_ir` clears IR.
  - If `i_reset_ir` and cmd 0x3 are both active, the IR load wins.
- `o_mem_we` = 1 only while cmd==0x9; it is combinational and never asserted in reset.
- Reset values:
  - PC=`RESET_PC`, SP=`RESET_SP`.
  - MA, MD, IR, A, AP = 0.
  - `o_out_data`=0, `o_out_valid`=0.
- Reset mid-operation: all registers return to reset values asynchronously; any in-flight write is dropped because `o_mem_we` is forced to 0 while `i_rstn`=0.

## Timing
- Every command takes a single cycle.
- A register written by one command is visible to the next command in the following cycle.
- Memory read data must be stable before the clock edge ending the cmd 0x2 cycle; read latency is 0 cycles relative to MA.
- The memory write is committed by memory on the edge ending the cmd 0x9 cycle.
- `o_out_valid` is registered: high for exactly the cycle after cmd 0xD.
- `o_opcode` bypass is combinational from MD, so there is no added latency.
- No backpressure and no stall output: the control unit sequence is trusted.

## Structure
- Shared package `edulent_pkg`:
  - enum `transfer_cmd_t` (XFER_NONE…XFER_MD_PC, 0x0–0xF).
  - `SP_INC`=2'b01 and `SP_DEC`=2'b10.
  - opcode constant `OP_CALL`=8'hC1.
- `control_unit` is updated to drive `transfer_cmd_t`.
- Sub-module `addr_counter`:
  - parameterised AW register with reset value, load (priority), increment and decrement.
  - instantiated once for PC and once for SP.

## Test plan
- Fetch: reset, mem[0x00]=0x19, mem[0x01]=0x5A; drive 1, 2+inc_pc, 3 (`o_opcode` = 0x19 during 3), 1, 2+inc_pc, 5 → A=0x5A, AP=0, PC=0x02.
- AP select: IR=0x1B, MD=0x33, cmd 5 → AP=0x33, A unchanged; IR=0x23, AP=0x33, cmd 8 → MD=0x33.
- Push/pop: SP=0xFF, A=0x77, IR=0x2C, seq SP−1, 7, 8, 9 → mem[0xFE]=0x77, SP=0xFE; pop seq 7, 2+SP+1 → MD=0x77, SP=0xFF.
- Wrap: PC=0xFF with inc_pc → PC=0x00; SP=0x00 with SP−1 → 0xFF; SP=0xFF with SP+1 → 0x00.
- Priority: PC=0x10, MD=0x40, cmd B + inc_pc → PC=0x40; cmd 3 + reset_ir with MD=0x50 → IR=0x50; ALU R=0x12 with res_to_ap=1, cmd A → AP=0x12.
- I/O and reset: `i_in_data`=0xC3, cmd C, cmd D → `o_out_data`=0xC3 with a one-cycle valid pulse; assert `i_rstn`=0 mid-cmd-9 → `o_mem_we`=0 immediately, all registers at reset values.

Source files
------------

// File: rtl/edulent_pkg.sv
// Shared definitions for the edulent control unit / datapath pair:
// transfer command codes, SP step encodings and opcode constants.
package edulent_pkg;

  typedef enum logic [3:0] {
    XFER_NONE    = 4'h0,
    XFER_MA_PC   = 4'h1,
    XFER_MD_MEM  = 4'h2,
    XFER_IR_MD   = 4'h3,
    XFER_MA_MD   = 4'h4,
    XFER_X_MD    = 4'h5,
    XFER_MA_AP   = 4'h6,
    XFER_MA_SP   = 4'h7,
    XFER_MD_X    = 4'h8,
    XFER_MEM_WR  = 4'h9,
    XFER_ALU_RES = 4'hA,
    XFER_PC_MD   = 4'hB,
    XFER_A_IN    = 4'hC,
    XFER_OUT_A   = 4'hD,
    XFER_PC_AP   = 4'hE,
    XFER_MD_PC   = 4'hF
  } transfer_cmd_t;

  localparam logic [1:0] SP_INC = 2'b01;
  localparam logic [1:0] SP_DEC = 2'b10;

  localparam logic [7:0] OP_CALL = 8'hC1;

endpackage

// File: rtl/addr_counter.sv
// Address register with reset value, priority load and wrapping +1/-1 step.
// Used for both PC and SP.
module addr_counter #(
  parameter int             AW        = 8,
  parameter logic [AW-1:0]  RESET_VAL = '0
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          load,
  input  logic [AW-1:0] load_value,
  input  logic          inc,
  input  logic          dec,
  output logic [AW-1:0] count
);

  localparam logic [AW-1:0] ONE = AW'(1);

  // Load beats any step; inc and dec together cancel to a hold.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count <= RESET_VAL;
    end else if (load) begin
      count <= load_value;
    end else if (inc && !dec) begin
      count <= count + ONE;
    end else if (dec && !inc) begin
      count <= count - ONE;
    end
  end

endmodule

// File: rtl/transfer_datapath.sv
// Register-transfer datapath driven one transfer command per cycle by the
// control unit; holds PC, SP, MA, MD, IR, A, AP and the output port register.
module transfer_datapath
  import edulent_pkg::*;
#(
  parameter int            AW       = 8,
  parameter int            DW       = 8,
  parameter logic [AW-1:0] RESET_PC = 'h00,
  parameter logic [AW-1:0] RESET_SP = 'hFF
) (
  input  logic          i_clk,
  input  logic          i_rstn,
  input  logic [3:0]    i_transfer_cmd,
  input  logic          i_inc_pc,
  input  logic [1:0]    i_inc_dec_sp,
  input  logic          i_alu_res_to_ap,
  input  logic          i_reset_ir,
  input  logic [DW-1:0] i_alu_result,
  output logic [DW-1:0] o_opcode,
  output logic [DW-1:0] o_alu_op_a,
  output logic [DW-1:0] o_alu_op_b,
  output logic [AW-1:0] o_mem_addr,
  output logic          o_mem_we,
  output logic [DW-1:0] o_mem_wdata,
  input  logic [DW-1:0] i_mem_rdata,
  input  logic [DW-1:0] i_in_data,
  output logic [DW-1:0] o_out_data,
  output logic          o_out_valid,
  output logic [AW-1:0] o_pc,
  output logic [AW-1:0] o_sp
);

  // Addresses and data share one bus width (DW == AW), so MD/AP move
  // freely between address and data registers.
  transfer_cmd_t cmd;
  logic [AW-1:0] pc;
  logic [AW-1:0] sp;
  logic [AW-1:0] ma;
  logic [DW-1:0] md;
  logic [DW-1:0] ir;
  logic [DW-1:0] a;
  logic [AW-1:0] ap;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          pc_load;
  logic [AW-1:0] pc_load_value;
  logic          x_is_ap;
  logic [DW-1:0] x_value;

  assign cmd = transfer_cmd_t'(i_transfer_cmd);

  assign pc_load       = (cmd == XFER_PC_MD) || (cmd == XFER_PC_AP);
  assign pc_load_value = (cmd == XFER_PC_MD) ? md : ap;

  addr_counter #(.AW(AW), .RESET_VAL(RESET_PC)) u_pc (
    .clk        (i_clk),
    .rstn       (i_rstn),
    .load       (pc_load),
    .load_value (pc_load_value),
    .inc        (i_inc_pc),
    .dec        (1'b0),
    .count      (pc)
  );

  addr_counter #(.AW(AW), .RESET_VAL(RESET_SP)) u_sp (
    .clk        (i_clk),
    .rstn       (i_rstn),
    .load       (1'b0),
    .load_value ('0),
    .inc        (i_inc_dec_sp == SP_INC),
    .dec        (i_inc_dec_sp == SP_DEC),
    .count      (sp)
  );

  // CALL and any opcode with bit 1 set move operands through AP instead of A.
  assign x_is_ap = (ir == DW'(OP_CALL)) || ir[1];
  assign x_value = x_is_ap ? ap : a;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      ma        <= '0;
      md        <= '0;
      ir        <= '0;
      a         <= '0;
      ap        <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= (cmd == XFER_OUT_A);
      if (cmd != XFER_IR_MD && i_reset_ir) begin
        ir <= '0;
      end
      case (cmd)
        XFER_MA_PC:   ma <= pc;
        XFER_MD_MEM:  md <= i_mem_rdata;
        XFER_IR_MD:   ir <= md;
        XFER_MA_MD:   ma <= md;
        XFER_X_MD: begin
          if (x_is_ap) ap <= md;
          else         a  <= md;
        end
        XFER_MA_AP:   ma <= ap;
        XFER_MA_SP:   ma <= sp;
        XFER_MD_X:    md <= x_value;
        XFER_ALU_RES: begin
          if (i_alu_res_to_ap) ap <= i_alu_result;
          else                 a  <= i_alu_result;
        end
        XFER_A_IN:    a <= i_in_data;
        XFER_OUT_A:   out_data <= a;
        XFER_MD_PC:   md <= pc;
        default: ;
      endcase
    end
  end

  // o_out_valid is a push-only strobe (no ready): o_out_data is new in the
  // single cycle o_out_valid is high and must be taken then.
  assign o_opcode    = (cmd == XFER_IR_MD) ? md : ir;
  assign o_mem_we    = i_rstn && (cmd == XFER_MEM_WR);
  assign o_mem_addr  = ma;
  assign o_mem_wdata = md;
  assign o_alu_op_a  = a;
  assign o_alu_op_b  = md;
  assign o_out_data  = out_data;
  assign o_out_valid = out_valid;
  assign o_pc        = pc;
  assign o_sp        = sp;

endmodule

// File: tb/tb_transfer_datapath.sv
// Self-checking bench for transfer_datapath: directed scenarios with literal
// expectations plus randomized command streams checked against a model.
module tb_transfer_datapath;

  logic       i_clk;
  logic       i_rstn;
  logic [3:0] cmd;
  logic       inc_pc;
  logic [1:0] sp_ctl;
  logic       ap_sel;
  logic       reset_ir;
  logic [7:0] alu_result;
  logic [7:0] in_data;
  logic [7:0] mem_rdata;
  logic [7:0] o_opcode, o_alu_op_a, o_alu_op_b, o_mem_addr, o_mem_wdata;
  logic [7:0] o_out_data, o_pc, o_sp;
  logic       o_mem_we, o_out_valid;

  int checks;
  int failures;

  transfer_datapath dut (
    .i_clk           (i_clk),
    .i_rstn          (i_rstn),
    .i_transfer_cmd  (cmd),
    .i_inc_pc        (inc_pc),
    .i_inc_dec_sp    (sp_ctl),
    .i_alu_res_to_ap (ap_sel),
    .i_reset_ir      (reset_ir),
    .i_alu_result    (alu_result),
    .o_opcode        (o_opcode),
    .o_alu_op_a      (o_alu_op_a),
    .o_alu_op_b      (o_alu_op_b),
    .o_mem_addr      (o_mem_addr),
    .o_mem_we        (o_mem_we),
    .o_mem_wdata     (o_mem_wdata),
    .i_mem_rdata     (mem_rdata),
    .i_in_data       (in_data),
    .o_out_data      (o_out_data),
    .o_out_valid     (o_out_valid),
    .o_pc            (o_pc),
    .o_sp            (o_sp)
  );

  // ---------------- clock / reset ----------------
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // ---------------- memory attached to the DUT ----------------
  logic [7:0] mem [256];
  logic       poke_en;
  logic [7:0] poke_addr;
  logic [7:0] poke_data;

  assign mem_rdata = mem[o_mem_addr];

  always @(posedge i_clk) begin
    if (o_mem_we) mem[o_mem_addr] <= o_mem_wdata;
    if (poke_en)  mem[poke_addr]  <= poke_data;
  end

  // ---------------- behavioural model ----------------
  logic [7:0] m_pc, m_sp, m_ma, m_md, m_ir, m_a, m_ap, m_out_data;
  logic       m_out_valid;
  logic [7:0] exp_mem [256];
  logic [7:0] exp_q [$];
  logic       m_use_ap;

  assign m_use_ap = (m_ir == 8'hC1) || m_ir[1];

  always @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      m_pc <= 8'h00; m_sp <= 8'hFF;
      m_ma <= 8'h00; m_md <= 8'h00; m_ir <= 8'h00; m_a <= 8'h00; m_ap <= 8'h00;
      m_out_data <= 8'h00; m_out_valid <= 1'b0;
      exp_q.delete();
    end else begin
      if (poke_en) exp_mem[poke_addr] <= poke_data;
      case (cmd)
        4'h1: m_ma <= m_pc;
        4'h2: m_md <= exp_mem[m_ma];
        4'h3: m_ir <= m_md;
        4'h4: m_ma <= m_md;
        4'h5: if (m_use_ap) m_ap <= m_md; else m_a <= m_md;
        4'h6: m_ma <= m_ap;
        4'h7: m_ma <= m_sp;
        4'h8: m_md <= m_use_ap ? m_ap : m_a;
        4'h9: exp_mem[m_ma] <= m_md;
        4'hA: if (ap_sel) m_ap <= alu_result; else m_a <= alu_result;
        4'hC: m_a <= in_data;
        4'hD: begin m_out_data <= m_a; exp_q.push_back(m_a); end
        4'hF: m_md <= m_pc;
        default: ;
      endcase
      if (reset_ir && cmd != 4'h3) m_ir <= 8'h00;
      if (cmd == 4'hB)      m_pc <= m_md;
      else if (cmd == 4'hE) m_pc <= m_ap;
      else if (inc_pc)      m_pc <= 8'((int'(m_pc) + 1) % 256);
      if (sp_ctl == 2'b01)      m_sp <= 8'((int'(m_sp) + 1) % 256);
      else if (sp_ctl == 2'b10) m_sp <= 8'((int'(m_sp) + 255) % 256);
      m_out_valid <= (cmd == 4'hD);
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge i_clk) begin
    if (i_rstn) begin
      chk("pc", o_pc, m_pc);
      chk("sp", o_sp, m_sp);
      chk("mem_addr", o_mem_addr, m_ma);
      chk("alu_op_a", o_alu_op_a, m_a);
      chk("alu_op_b", o_alu_op_b, m_md);
      chk("mem_wdata", o_mem_wdata, m_md);
      chk("opcode", o_opcode, (cmd == 4'h3) ? m_md : m_ir);
      chk("mem_we", o_mem_we, cmd == 4'h9);
      chk("out_valid", o_out_valid, m_out_valid);
      chk("out_data", o_out_data, m_out_data);
      if (o_out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL out_q actual=%0h required=no_output", o_out_data);
        end else begin
          chk("out_q", o_out_data, exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [3:0] c, input logic inc = 1'b0,
                       input logic [1:0] spc = 2'b00, input logic aps = 1'b0,
                       input logic rir = 1'b0, input logic [7:0] alu = 8'h00,
                       input logic [7:0] din = 8'h00);
    cmd = c; inc_pc = inc; sp_ctl = spc; ap_sel = aps;
    reset_ir = rir; alu_result = alu; in_data = din;
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic step(input logic [3:0] c, input logic inc = 1'b0,
                      input logic [1:0] spc = 2'b00, input logic aps = 1'b0,
                      input logic rir = 1'b0, input logic [7:0] alu = 8'h00,
                      input logic [7:0] din = 8'h00);
    drive(c, inc, spc, aps, rir, alu, din);
    tick();
  endtask

  task automatic poke(input logic [7:0] addr, input logic [7:0] data);
    poke_en = 1'b1; poke_addr = addr; poke_data = data;
    step(4'h0);
    poke_en = 1'b0;
  endtask

  task automatic set_md(input logic [7:0] v);
    poke(m_pc, v);
    step(4'h1);
    step(4'h2, 1'b1);
  endtask

  task automatic set_ir(input logic [7:0] v);
    set_md(v);
    step(4'h3);
  endtask

  task automatic set_pc(input logic [7:0] v);
    set_md(v);
    step(4'hB);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    checks = 0; failures = 0;
    poke_en = 1'b0; poke_addr = 8'h00; poke_data = 8'h00;
    i_rstn = 1'b0;
    drive(4'h0);
    for (int i = 0; i < 256; i++) begin mem[i] = 8'h00; exp_mem[i] = 8'h00; end
    @(posedge i_clk); @(posedge i_clk); #1;
    chk("rst_pc", o_pc, 8'h00);
    chk("rst_sp", o_sp, 8'hFF);
    chk("rst_ma", o_mem_addr, 8'h00);
    chk("rst_opcode", o_opcode, 8'h00);
    chk("rst_we", o_mem_we, 1'b0);
    chk("rst_valid", o_out_valid, 1'b0);
    @(negedge i_clk);
    i_rstn = 1'b1;
    tick();

    for (int i = 2; i < 256; i++) poke(8'(i), 8'($urandom_range(0, 255)));
    poke(8'h00, 8'h19);
    poke(8'h01, 8'h5A);

    // fetch
    step(4'h1);
    step(4'h2, 1'b1);
    drive(4'h3);
    #1 chk("fetch_opcode_bypass", o_opcode, 8'h19);
    tick();
    step(4'h1);
    step(4'h2, 1'b1);
    step(4'h5);
    chk("fetch_a", o_alu_op_a, 8'h5A);
    chk("fetch_pc", o_pc, 8'h02);
    step(4'h6);
    chk("fetch_ap", o_mem_addr, 8'h00);

    // AP select
    set_ir(8'h1B);
    step(4'hC, 0, 0, 0, 0, 8'h00, 8'h11);
    set_md(8'h33);
    step(4'h5);
    step(4'h6);
    chk("apsel_ap", o_mem_addr, 8'h33);
    chk("apsel_a_kept", o_alu_op_a, 8'h11);
    set_ir(8'h23);
    step(4'h8);
    chk("apsel_md_from_ap", o_alu_op_b, 8'h33);

    // push / pop
    step(4'hC, 0, 0, 0, 0, 8'h00, 8'h77);
    set_ir(8'h2C);
    step(4'h0, 0, 2'b10);
    step(4'h7);
    step(4'h8);
    step(4'h9);
    chk("push_mem", mem[8'hFE], 8'h77);
    chk("push_sp", o_sp, 8'hFE);
    step(4'h7);
    step(4'h2, 0, 2'b01);
    chk("pop_md", o_alu_op_b, 8'h77);
    chk("pop_sp", o_sp, 8'hFF);

    // wrap
    set_pc(8'hFF);
    step(4'h0, 1'b1);
    chk("pc_wrap", o_pc, 8'h00);
    step(4'h0, 0, 2'b01);
    chk("sp_wrap_up", o_sp, 8'h00);
    step(4'h0, 0, 2'b10);
    chk("sp_wrap_down", o_sp, 8'hFF);

    // priority
    set_pc(8'h10);
    set_md(8'h40);
    step(4'hB, 1'b1);
    chk("pc_load_over_inc", o_pc, 8'h40);
    set_md(8'h50);
    step(4'h3, 0, 0, 0, 1'b1);
    step(4'h0);
    chk("ir_load_over_reset", o_opcode, 8'h50);
    step(4'h0, 0, 0, 0, 1'b1);
    chk("ir_reset", o_opcode, 8'h00);
    step(4'hA, 0, 0, 1'b1, 0, 8'h12);
    step(4'h6);
    chk("alu_to_ap", o_mem_addr, 8'h12);

    // I/O
    step(4'hC, 0, 0, 0, 0, 8'h00, 8'hC3);
    step(4'hD);
    chk("out_valid_pulse", o_out_valid, 1'b1);
    chk("out_data", o_out_data, 8'hC3);
    step(4'h0);
    chk("out_valid_drop", o_out_valid, 1'b0);

    // reset during a memory write
    set_md(8'h5C);
    step(4'h4);
    drive(4'h9);
    #2 chk("we_before_reset", o_mem_we, 1'b1);
    i_rstn = 1'b0;
    #1;
    chk("we_in_reset", o_mem_we, 1'b0);
    chk("mid_rst_pc", o_pc, 8'h00);
    chk("mid_rst_sp", o_sp, 8'hFF);
    chk("mid_rst_ma", o_mem_addr, 8'h00);
    chk("mid_rst_md", o_alu_op_b, 8'h00);
    chk("mid_rst_a", o_alu_op_a, 8'h00);
    chk("mid_rst_ir", o_opcode, 8'h00);
    chk("mid_rst_out", o_out_data, 8'h00);
    tick();
    chk("write_dropped", mem[8'h5C], exp_mem[8'h5C]);
    drive(4'h0);
    @(negedge i_clk);
    i_rstn = 1'b1;
    tick();

    // randomized command stream
    for (int n = 0; n < 1500; n++) begin
      step(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
           2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 7) == 0), 8'($urandom_range(0, 255)),
           8'($urandom_range(0, 255)));
    end
    step(4'h0);
    step(4'h0);
    chk("out_q_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
